// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer_counter peripheral: FSM states, register
// offsets, CTRL bit positions and mode encodings.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;
  localparam logic [1:0] TC_ACK    = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  // Modes 2 and 3 fall back to one-shot behaviour.
  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter_regs.sv
// Bus-visible register file (CTRL, PRESET) and the read mux for offsets 0-2.
module timer_counter_regs
  import timer_counter_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         addr_i,
  input  logic               we_i,
  input  logic [31:0]        wdata_i,
  input  logic               en_clr_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic               en_o,
  output logic [1:0]         mode_o,
  output logic               im_o,
  output logic [COUNT_W-1:0] preset_o,
  output logic               ctrl_wr_o,
  output logic [31:0]        rdata_o
);

  logic               en_q;
  logic [1:0]         mode_q;
  logic               im_q;
  logic [COUNT_W-1:0] preset_q;

  assign ctrl_wr_o = we_i && (addr_i == TC_CTRL);

  // A bus write to CTRL takes precedence over the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= '0;
    end else begin
      if (ctrl_wr_o) begin
        en_q   <= wdata_i[CTRL_EN];
        mode_q <= wdata_i[CTRL_MODE_HI:CTRL_MODE_LO];
        im_q   <= wdata_i[CTRL_IM];
      end else if (en_clr_i) begin
        en_q <= 1'b0;
      end
      if (we_i && (addr_i == TC_PRESET)) begin
        preset_q <= wdata_i[COUNT_W-1:0];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      TC_CTRL: begin
        rdata_o[CTRL_EN]                   = en_q;
        rdata_o[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
        rdata_o[CTRL_IM]                   = im_q;
      end
      TC_PRESET: rdata_o[COUNT_W-1:0] = preset_q;
      TC_COUNT:  rdata_o[COUNT_W-1:0] = count_i;
      default:   rdata_o = '0;
    endcase
  end

  assign en_o     = en_q;
  assign mode_o   = mode_q;
  assign im_o     = im_q;
  assign preset_o = preset_q;

endmodule

// File: rtl/timer_counter.sv
// Countdown timer with one-shot / auto-reload modes and a maskable irq.
// Build option TIMER_COUNTER_ACK_EN adds a write-to-clear ACK register at offset 3.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_state_e          state_q;
  logic [COUNT_W-1:0] count_q;
  logic               irq_flag_q;

  logic               en;
  logic [1:0]         mode;
  logic               im;
  logic [COUNT_W-1:0] preset;
  logic               ctrl_wr;
  logic               ack_wr;
  logic               en_clr;
  logic [31:0]        regs_rdata;

  assign en_clr = (state_q == INT) && !is_reload(mode);

  timer_counter_regs #(
    .COUNT_W (COUNT_W)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .addr_i    (addr),
    .we_i      (we),
    .wdata_i   (wdata),
    .en_clr_i  (en_clr),
    .count_i   (count_q),
    .en_o      (en),
    .mode_o    (mode),
    .im_o      (im),
    .preset_o  (preset),
    .ctrl_wr_o (ctrl_wr),
    .rdata_o   (regs_rdata)
  );

`ifdef TIMER_COUNTER_ACK_EN
  assign ack_wr = we && (addr == TC_ACK);
  assign rdata  = (addr == TC_ACK) ? {31'b0, irq_flag_q} : regs_rdata;
`else
  assign ack_wr = 1'b0;
  assign rdata  = regs_rdata;
`endif

  // Later assignments win: INT setting the flag beats a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      if (ctrl_wr || ack_wr) begin
        irq_flag_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (en) state_q <= LOAD;
        end
        LOAD: begin
          count_q <= preset;
          state_q <= CNT;
          if (is_reload(mode)) irq_flag_q <= 1'b0;
        end
        CNT: begin
          if (!en) begin
            state_q <= IDLE;
          end else if (count_q <= COUNT_W'(1)) begin
            count_q <= '0;
            state_q <= INT;
          end else begin
            count_q <= count_q - COUNT_W'(1);
          end
        end
        INT: begin
          irq_flag_q <= 1'b1;
          state_q    <= is_reload(mode) ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq = irq_flag_q & im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; expectations are hand-derived
// edge by edge from the enabling CTRL write (edge E0).
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] d;

  timer_counter #(.COUNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    we    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Write is sampled at the next rising edge; returns 1 ns after that edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    addr  = a;
    wdata = v;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'd0) begin
        $display("FAIL reset_rdata[%0d]: got %h expected 00000000", a, d); errors++;
      end
    end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", irq); errors++; end
  endtask

  task automatic test_oneshot();
    bus_write(TC_PRESET, 32'd5);
    bus_write(TC_CTRL, 32'h9);
    step();                                  // E1: LOAD
    for (int k = 2; k <= 7; k++) begin       // E2..E7: COUNT 5..0
      step();
      rd(TC_COUNT, d);
      checks++;
      if (d !== 32'(7 - k)) begin
        $display("FAIL oneshot_count@E%0d: got %0d expected %0d", k, d, 7 - k); errors++;
      end
      checks++;
      if (irq !== 1'b0) begin $display("FAIL oneshot_irq_early@E%0d: got %b expected 0", k, irq); errors++; end
    end
    step();                                  // E8: INT exit, flag set, EN cleared
    checks++;
    if (irq !== 1'b1) begin $display("FAIL oneshot_irq_rise: got %b expected 1", irq); errors++; end
    rd(TC_CTRL, d);
    checks++;
    if (d !== 32'h8) begin $display("FAIL oneshot_ctrl_en_clr: got %h expected 8", d); errors++; end
    repeat (3) step();
    checks++;
    if (irq !== 1'b1) begin $display("FAIL oneshot_irq_hold: got %b expected 1", irq); errors++; end
    bus_write(TC_CTRL, 32'h8);
    checks++;
    if (irq !== 1'b0) begin $display("FAIL oneshot_ctrl_ack: got %b expected 0", irq); errors++; end
  endtask

  task automatic test_reload();
    int cnt_tbl[5] = '{3, 2, 1, 0, 0};
    logic exp_irq;
    do_reset();
    bus_write(TC_PRESET, 32'd3);
    bus_write(TC_CTRL, 32'hB);
    for (int e = 1; e <= 23; e++) begin
      step();
      exp_irq = (e >= 6) && ((e - 6) % 5 == 0);
      checks++;
      if (irq !== exp_irq) begin $display("FAIL reload_irq@E%0d: got %b expected %b", e, irq, exp_irq); errors++; end
      if (e >= 2) begin
        rd(TC_COUNT, d);
        checks++;
        if (d !== 32'(cnt_tbl[(e - 2) % 5])) begin
          $display("FAIL reload_count@E%0d: got %0d expected %0d", e, d, cnt_tbl[(e - 2) % 5]); errors++;
        end
      end
    end
    rd(TC_CTRL, d);
    checks++;
    if (d !== 32'hB) begin $display("FAIL reload_ctrl_kept: got %h expected b", d); errors++; end
  endtask

  task automatic test_short_reload();
    logic exp_irq;
    for (int p = 0; p <= 1; p++) begin
      do_reset();
      bus_write(TC_PRESET, 32'(p));
      bus_write(TC_CTRL, 32'hB);
      for (int e = 1; e <= 12; e++) begin
        step();
        exp_irq = (e >= 4) && ((e - 4) % 3 == 0);
        checks++;
        if (irq !== exp_irq) begin
          $display("FAIL short_reload_p%0d_irq@E%0d: got %b expected %b", p, e, irq, exp_irq); errors++;
        end
      end
    end
  endtask

  task automatic test_masked();
    do_reset();
    bus_write(TC_PRESET, 32'd2);
    bus_write(TC_CTRL, 32'h1);
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (irq !== 1'b0) begin $display("FAIL masked_irq@E%0d: got %b expected 0", e, irq); errors++; end
    end
    rd(TC_CTRL, d);
    checks++;
    if (d !== 32'h0) begin $display("FAIL masked_ctrl: got %h expected 0", d); errors++; end
`ifdef TIMER_COUNTER_ACK_EN
    rd(TC_ACK, d);
    checks++;
    if (d !== 32'h1) begin $display("FAIL masked_flag_pending: got %h expected 1", d); errors++; end
`endif
    bus_write(TC_CTRL, 32'h8);
    repeat (2) step();
    checks++;
    if (irq !== 1'b0) begin $display("FAIL masked_unmask_lost: got %b expected 0", irq); errors++; end
`ifdef TIMER_COUNTER_ACK_EN
    rd(TC_ACK, d);
    checks++;
    if (d !== 32'h0) begin $display("FAIL masked_flag_cleared: got %h expected 0", d); errors++; end
`endif
  endtask

  task automatic test_collision();
    do_reset();
    bus_write(TC_PRESET, 32'd2);
    bus_write(TC_CTRL, 32'h1);
    repeat (4) step();                       // at E4; INT occupies E4..E5
    bus_write(TC_CTRL, 32'h9);               // sampled at E5, same edge INT sets flag
    checks++;
    if (irq !== 1'b1) begin $display("FAIL collision_irq: got %b expected 1", irq); errors++; end
    rd(TC_CTRL, d);
    checks++;
    if (d !== 32'h9) begin $display("FAIL collision_ctrl_bus_wins: got %h expected 9", d); errors++; end
  endtask

  task automatic test_preset_midcount();
    do_reset();
    bus_write(TC_PRESET, 32'd4);
    bus_write(TC_CTRL, 32'h9);
    repeat (2) step();                       // E2: COUNT=4
    bus_write(TC_PRESET, 32'd20);            // sampled at E3
    rd(TC_COUNT, d);
    checks++;
    if (d !== 32'd3) begin $display("FAIL midcount_e3: got %0d expected 3", d); errors++; end
    step();
    rd(TC_COUNT, d);
    checks++;
    if (d !== 32'd2) begin $display("FAIL midcount_e4: got %0d expected 2", d); errors++; end
    repeat (2) step();                       // E6: INT
    checks++;
    if (irq !== 1'b0) begin $display("FAIL midcount_irq_e6: got %b expected 0", irq); errors++; end
    step();                                  // E7
    checks++;
    if (irq !== 1'b1) begin $display("FAIL midcount_irq_e7: got %b expected 1", irq); errors++; end
    rd(TC_PRESET, d);
    checks++;
    if (d !== 32'd20) begin $display("FAIL midcount_preset: got %0d expected 20", d); errors++; end
  endtask

  task automatic test_pause_and_reset();
    do_reset();
    bus_write(TC_PRESET, 32'd10);
    bus_write(TC_CTRL, 32'h9);
    repeat (5) step();                       // E5: COUNT=7
    bus_write(TC_CTRL, 32'h8);               // sampled at E6 as COUNT becomes 6
    repeat (5) step();
    rd(TC_COUNT, d);
    checks++;
    if (d !== 32'd6) begin $display("FAIL pause_count_hold: got %0d expected 6", d); errors++; end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL pause_irq: got %b expected 0", irq); errors++; end
    bus_write(TC_CTRL, 32'h9);
    repeat (3) step();                       // E3 after re-enable: COUNT=9
    rd(TC_COUNT, d);
    checks++;
    if (d !== 32'd9) begin $display("FAIL pause_restart_count: got %0d expected 9", d); errors++; end
    @(negedge clk);
    reset = 1'b1;
    step();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      checks++;
      if (d !== 32'd0) begin $display("FAIL midrun_reset_rdata[%0d]: got %h expected 00000000", a, d); errors++; end
    end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL midrun_reset_irq: got %b expected 0", irq); errors++; end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_ack();
    do_reset();
    bus_write(TC_PRESET, 32'd1);
    bus_write(TC_CTRL, 32'h9);
    repeat (5) step();
    checks++;
    if (irq !== 1'b1) begin $display("FAIL ack_pre_irq: got %b expected 1", irq); errors++; end
    bus_write(TC_ACK, 32'hFFFF_FFFF);
`ifdef TIMER_COUNTER_ACK_EN
    checks++;
    if (irq !== 1'b0) begin $display("FAIL ack_irq_clear: got %b expected 0", irq); errors++; end
`else
    checks++;
    if (irq !== 1'b1) begin $display("FAIL ack_ignored_irq: got %b expected 1", irq); errors++; end
`endif
    rd(TC_ACK, d);
    checks++;
    if (d !== 32'd0) begin $display("FAIL ack_readback: got %h expected 0", d); errors++; end
    rd(TC_CTRL, d);
    checks++;
    if (d !== 32'h8) begin $display("FAIL ack_ctrl_unchanged: got %h expected 8", d); errors++; end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_reload();
    test_short_reload();
    test_masked();
    test_collision();
    test_preset_midcount();
    test_pause_and_reset();
    test_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
